uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 16x-oversampling UART receiver; the receive-side counterpart of the team's uart_tx.
- Shares the same s_tick baud generator (16 ticks per bit).
- Recovers start, DBIT data bits (LSB first), an optional parity bit and the stop bit from the serial line.
- Presents the received word with a one-cycle done strobe, plus framing and parity error flags, to the UART FIFO/interface layer.

Parameters:
- DBIT, 8, number of data bits per frame (5..9).
- SB_TICK, 16, s_tick count for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, asynchronous to clk, idle high.
- s_tick  input  1  oversampling enable, one clk wide, 16 per bit period.
- dout  output  DBIT  last received data word.
- rx_done_tick  output  1  one-clk pulse when a frame completes.
- frame_err  output  1  one-clk pulse, coincident with rx_done_tick; stop bit sampled low.
- parity_err  output  1  one-clk pulse, coincident with rx_done_tick; parity mismatch (always 0 when PARITY=0).

Behaviour:
- Input synchroniser:
  - rx passes through a 2-FF synchroniser (rx_s); both flops reset to 1.
  - All decisions use rx_s, so line-to-decision latency is 2 clk.
- Reset values:
  - State = IDLE, armed = 1, all counters 0, shift register 0.
  - dout = 0; rx_done_tick, frame_err and parity_err all 0.
- Counters:
  - s counter wide enough for max(15, SB_TICK-1).
  - n counter wide enough for DBIT-1.
  - s advances only on s_tick; with no s_tick the FSM holds.
- IDLE:
  - If armed and rx_s==0: go to START, s=0.
  - rx_s==1 sets armed.
- START:
  - On s_tick with s==7 (mid start bit): if rx_s==0 go to DATA with s=0, n=0; if rx_s==1 (glitch) return to IDLE.
  - Otherwise s increments.
- DATA:
  - On s_tick with s==15: sample rx_s, shift right into the register (msb <- rx_s, so after DBIT shifts bit0 = first data bit), s=0.
  - If n==DBIT-1: go to PARITY when PARITY!=0, else STOP. Otherwise n increments.
  - Sampling thus occurs at mid-bit for every data bit.
- PARITY (only when PARITY!=0):
  - On s_tick with s==15: capture rx_s as the parity bit, go to STOP, s=0.
  - Expected parity = XOR of data bits for even, its inverse for odd.
- STOP:
  - On s_tick with s==SB_TICK-1, on the next clk:
    - dout <= shift register.
    - rx_done_tick=1.
    - frame_err = (rx_s==0).
    - parity_err = mismatch.
    - Go to IDLE.
  - On a framing error also clear armed, so a held-low line (break) cannot retrigger until rx_s returns high.
- Output timing:
  - All outputs are registered.
  - dout holds its value until the next completed frame; it is updated even on error.
  - Error flags are only ever high together with rx_done_tick.
- s_tick arriving in the same clk as a state transition counts toward the old state only; no tick is double-counted.
- Reset mid-frame: immediately returns to IDLE with reset values; the partial frame is discarded with no strobe.
- Back-to-back frames: a start edge may be detected in the IDLE cycle right after STOP completes, with no idle bit required.

Test Plan:
- s_tick every clk, PARITY=0, send 0xA5 (8N1) -> exactly one rx_done_tick about 10*16 clk after the start edge (+2 sync); dout=0xA5; frame_err=0; parity_err=0.
- PARITY=1 (even), send 0x37 with parity 1, then 0x37 with parity 0 -> first frame parity_err=0, second frame parity_err=1; dout=0x37 both times.
- Send 0x5A with the stop bit forced low, then hold rx low for 40 bit times, then release -> one strobe with frame_err=1 and dout=0x5A; no further strobes while low; a subsequent normal frame 0x3C is received correctly.
- Low glitch on rx of 4 ticks while idle -> no rx_done_tick; FSM back in IDLE; a following 0xFF frame is received correctly.
- Assert reset during data bit 4 of a frame -> all outputs 0 the same cycle, no strobe; the next full frame 0x81 is received cleanly.
- Two back-to-back frames 0x01 and 0x80 with zero idle gap, s_tick every 3rd clk -> two strobes with dout=0x01 then 0x80, no errors.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receiver-side serial bundle: line and oversampling tick in, received word and status strobes out.
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            parity_err;

  modport master (
    output rx, s_tick,
    input  dout, rx_done_tick, frame_err, parity_err
  );

  modport slave (
    input  rx, s_tick,
    output dout, rx_done_tick, frame_err, parity_err
  );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: start/data/optional parity/stop recovery with
// registered word, done strobe and framing/parity error pulses.
//
// state | meaning
// IDLE  | waiting for a low line while armed
// START | counting to mid start bit to reject glitches
// DATA  | sampling DBIT data bits at mid-bit, LSB first
// PAR   | sampling the parity bit (PARITY != 0 only)
// STOP  | sampling the stop bit, then publishing the frame
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);

  localparam int S_MAX = (SB_TICK - 1 > 15) ? SB_TICK - 1 : 15;
  localparam int SW    = $clog2(S_MAX + 1);
  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_ONE      = SW'(1);
  localparam logic [SW-1:0] S_MID      = SW'(7);
  localparam logic [SW-1:0] S_BIT_END  = SW'(15);
  localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_ONE      = NW'(1);
  localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t          state_reg, state_next;
  logic [1:0]      sync_q;
  logic            rx_s;
  logic [SW-1:0]   s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            p_reg, p_next;
  logic            armed_reg, armed_next;
  logic [DBIT-1:0] dout_reg, dout_next;
  logic            done_reg, done_next;
  logic            ferr_reg, ferr_next;
  logic            perr_reg, perr_next;
  logic            par_mismatch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.rx};
    end
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      p_reg     <= 1'b0;
      armed_reg <= 1'b1;
      dout_reg  <= '0;
      done_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
      perr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      p_reg     <= p_next;
      armed_reg <= armed_next;
      dout_reg  <= dout_next;
      done_reg  <= done_next;
      ferr_reg  <= ferr_next;
      perr_reg  <= perr_next;
    end
  end

  // Odd parity expects the inverse of the data XOR, so a mismatch is the inverse too.
  always_comb begin
    par_mismatch = 1'b0;
    if (PARITY == 1) begin
      par_mismatch = p_reg ^ (^b_reg);
    end else if (PARITY == 2) begin
      par_mismatch = ~(p_reg ^ (^b_reg));
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    p_next     = p_reg;
    armed_next = armed_reg;
    dout_next  = dout_reg;
    done_next  = 1'b0;
    ferr_next  = 1'b0;
    perr_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (rx_s) begin
          armed_next = 1'b1;
        end else if (armed_reg) begin
          state_next = START;
          s_next     = '0;
        end
      end

      START: begin
        if (bus.s_tick) begin
          if (s_reg == S_MID) begin
            if (!rx_s) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s_reg + S_ONE;
          end
        end
      end

      DATA: begin
        if (bus.s_tick) begin
          if (s_reg == S_BIT_END) begin
            s_next = '0;
            b_next = {rx_s, b_reg[DBIT-1:1]};
            if (n_reg == N_LAST) begin
              state_next = (PARITY != 0) ? PAR : STOP;
            end else begin
              n_next = n_reg + N_ONE;
            end
          end else begin
            s_next = s_reg + S_ONE;
          end
        end
      end

      PAR: begin
        if (bus.s_tick) begin
          if (s_reg == S_BIT_END) begin
            p_next     = rx_s;
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s_reg + S_ONE;
          end
        end
      end

      STOP: begin
        if (bus.s_tick) begin
          if (s_reg == S_STOP_END) begin
            state_next = IDLE;
            dout_next  = b_reg;
            done_next  = 1'b1;
            ferr_next  = ~rx_s;
            perr_next  = par_mismatch;
            // A low stop bit disarms until the line goes high, so a break cannot retrigger.
            armed_next = rx_s;
          end else begin
            s_next = s_reg + S_ONE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.dout         = dout_reg;
  assign bus.rx_done_tick = done_reg;
  assign bus.frame_err    = ferr_reg;
  assign bus.parity_err   = perr_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one 8N1 receiver and one 8E1 receiver driven from frame tasks.
module tb_uart_rx;

  logic clk;
  logic reset;
  logic tick;
  logic rx0;
  logic rx1;
  int   tick_div;
  int   cyc;
  int   checks;
  int   errors;
  int   stray_err;
  int   start_cyc;
  int   done_cyc0;

  logic [7:0] q_dout0[$];
  logic       q_ferr0[$];
  logic       q_perr0[$];
  logic [7:0] q_dout1[$];
  logic       q_ferr1[$];
  logic       q_perr1[$];

  uart_rx_if #(.DBIT(8)) if0 ();
  uart_rx_if #(.DBIT(8)) if1 ();

  assign if0.rx     = rx0;
  assign if0.s_tick = tick;
  assign if1.rx     = rx1;
  assign if1.s_tick = tick;

  uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Tick generator: one-clk-wide pulse every tick_div clocks, changed away from the active edge.
  initial begin
    int cnt;
    cnt  = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (cnt == 0);
      cnt  = (cnt + 1 >= tick_div) ? 0 : cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (if0.rx_done_tick) begin
      q_dout0.push_back(if0.dout);
      q_ferr0.push_back(if0.frame_err);
      q_perr0.push_back(if0.parity_err);
      done_cyc0 <= cyc;
    end
    if (if1.rx_done_tick) begin
      q_dout1.push_back(if1.dout);
      q_ferr1.push_back(if1.frame_err);
      q_perr1.push_back(if1.parity_err);
    end
    if (((if0.frame_err | if0.parity_err) & ~if0.rx_done_tick) |
        ((if1.frame_err | if1.parity_err) & ~if1.rx_done_tick))
      stray_err <= stray_err + 1;
  end

  task automatic drive_rx(input int sel, input logic v);
    if (sel == 0) rx0 = v;
    else          rx1 = v;
  endtask

  task automatic wait_ticks(input int nt);
    int c;
    c = 0;
    while (c < nt) begin
      @(posedge clk);
      if (tick) c++;
    end
  endtask

  task automatic send_bit(input int sel, input logic v, input int nt);
    @(negedge clk);
    drive_rx(sel, v);
    wait_ticks(nt);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] data, input bit par_en,
                            input logic par_bit, input logic stop_v);
    @(negedge clk);
    drive_rx(sel, 1'b0);
    start_cyc = cyc;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) send_bit(sel, data[i], 16);
    if (par_en) send_bit(sel, par_bit, 16);
    send_bit(sel, stop_v, 16);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    checks++;
    if (if0.dout !== 8'h00) begin
      errors++; $display("FAIL reset_dout0 got %h want 00", if0.dout);
    end
    checks++;
    if (if0.rx_done_tick !== 1'b0 || if0.frame_err !== 1'b0 || if0.parity_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags0 got %b%b%b want 000",
                         if0.rx_done_tick, if0.frame_err, if0.parity_err);
    end
    checks++;
    if (if1.dout !== 8'h00 || if1.rx_done_tick !== 1'b0) begin
      errors++; $display("FAIL reset_dut1 got %h/%b want 00/0", if1.dout, if1.rx_done_tick);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    send_bit(0, 1'b1, 4);
  endtask

  task automatic test_basic_8n1;
    int n0;
    tick_div = 1;
    n0 = q_dout0.size();
    send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
    send_bit(0, 1'b1, 16);
    checks++;
    if (q_dout0.size() !== n0 + 1) begin
      errors++; $display("FAIL basic_strobes got %0d want %0d", q_dout0.size() - n0, 1);
    end
    checks++;
    if (q_dout0[$] !== 8'hA5) begin
      errors++; $display("FAIL basic_dout got %h want a5", q_dout0[$]);
    end
    checks++;
    if (q_ferr0[$] !== 1'b0 || q_perr0[$] !== 1'b0) begin
      errors++; $display("FAIL basic_errs got %b%b want 00", q_ferr0[$], q_perr0[$]);
    end
    // 2 sync + 1 IDLE->START + 8 ticks to mid start + 9*16 to mid stop, seen one cycle later.
    checks++;
    if (done_cyc0 - start_cyc !== 155) begin
      errors++; $display("FAIL basic_latency got %0d want 155", done_cyc0 - start_cyc);
    end
  endtask

  task automatic test_parity;
    int n1;
    tick_div = 1;
    n1 = q_dout1.size();
    send_frame(1, 8'h37, 1, 1'b1, 1'b1);
    send_bit(1, 1'b1, 16);
    send_frame(1, 8'h37, 1, 1'b0, 1'b1);
    send_bit(1, 1'b1, 16);
    checks++;
    if (q_dout1.size() !== n1 + 2) begin
      errors++; $display("FAIL parity_strobes got %0d want 2", q_dout1.size() - n1);
    end else begin
      checks++;
      if (q_dout1[n1] !== 8'h37 || q_perr1[n1] !== 1'b0 || q_ferr1[n1] !== 1'b0) begin
        errors++; $display("FAIL parity_good got %h p%b f%b want 37 p0 f0",
                           q_dout1[n1], q_perr1[n1], q_ferr1[n1]);
      end
      checks++;
      if (q_dout1[n1+1] !== 8'h37 || q_perr1[n1+1] !== 1'b1 || q_ferr1[n1+1] !== 1'b0) begin
        errors++; $display("FAIL parity_bad got %h p%b f%b want 37 p1 f0",
                           q_dout1[n1+1], q_perr1[n1+1], q_ferr1[n1+1]);
      end
    end
  endtask

  task automatic test_break;
    int n0;
    tick_div = 1;
    n0 = q_dout0.size();
    send_frame(0, 8'h5A, 0, 1'b0, 1'b0);
    wait_ticks(640);
    checks++;
    if (q_dout0.size() !== n0 + 1) begin
      errors++; $display("FAIL break_strobes got %0d want 1", q_dout0.size() - n0);
    end
    checks++;
    if (q_dout0[n0] !== 8'h5A || q_ferr0[n0] !== 1'b1 || q_perr0[n0] !== 1'b0) begin
      errors++; $display("FAIL break_frame got %h f%b p%b want 5a f1 p0",
                         q_dout0[n0], q_ferr0[n0], q_perr0[n0]);
    end
    send_bit(0, 1'b1, 32);
    send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
    send_bit(0, 1'b1, 16);
    checks++;
    if (q_dout0.size() !== n0 + 2 || q_dout0[$] !== 8'h3C || q_ferr0[$] !== 1'b0) begin
      errors++; $display("FAIL break_recover got n%0d %h f%b want n2 3c f0",
                         q_dout0.size() - n0, q_dout0[$], q_ferr0[$]);
    end
  endtask

  task automatic test_glitch;
    int n0;
    tick_div = 1;
    n0 = q_dout0.size();
    send_bit(0, 1'b0, 4);
    send_bit(0, 1'b1, 32);
    checks++;
    if (q_dout0.size() !== n0) begin
      errors++; $display("FAIL glitch_strobes got %0d want 0", q_dout0.size() - n0);
    end
    send_frame(0, 8'hFF, 0, 1'b0, 1'b1);
    send_bit(0, 1'b1, 16);
    checks++;
    if (q_dout0.size() !== n0 + 1 || q_dout0[$] !== 8'hFF || q_ferr0[$] !== 1'b0) begin
      errors++; $display("FAIL glitch_after got n%0d %h f%b want n1 ff f0",
                         q_dout0.size() - n0, q_dout0[$], q_ferr0[$]);
    end
  endtask

  task automatic test_reset_midframe;
    int n0;
    logic [7:0] d;
    tick_div = 1;
    d  = 8'h81;
    n0 = q_dout0.size();
    send_bit(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(0, d[i], 16);
    send_bit(0, d[4], 8);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (if0.dout !== 8'h00 || if0.rx_done_tick !== 1'b0 || if0.frame_err !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got %h %b %b want 00 0 0",
                         if0.dout, if0.rx_done_tick, if0.frame_err);
    end
    rx0 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    send_bit(0, 1'b1, 32);
    checks++;
    if (q_dout0.size() !== n0) begin
      errors++; $display("FAIL midreset_strobes got %0d want 0", q_dout0.size() - n0);
    end
    send_frame(0, 8'h81, 0, 1'b0, 1'b1);
    send_bit(0, 1'b1, 16);
    checks++;
    if (q_dout0.size() !== n0 + 1 || q_dout0[$] !== 8'h81 || q_ferr0[$] !== 1'b0) begin
      errors++; $display("FAIL midreset_after got n%0d %h f%b want n1 81 f0",
                         q_dout0.size() - n0, q_dout0[$], q_ferr0[$]);
    end
  endtask

  task automatic test_back_to_back;
    int n0;
    tick_div = 3;
    n0 = q_dout0.size();
    send_frame(0, 8'h01, 0, 1'b0, 1'b1);
    send_frame(0, 8'h80, 0, 1'b0, 1'b1);
    send_bit(0, 1'b1, 32);
    checks++;
    if (q_dout0.size() !== n0 + 2) begin
      errors++; $display("FAIL b2b_strobes got %0d want 2", q_dout0.size() - n0);
    end else begin
      checks++;
      if (q_dout0[n0] !== 8'h01 || q_dout0[n0+1] !== 8'h80) begin
        errors++; $display("FAIL b2b_data got %h %h want 01 80", q_dout0[n0], q_dout0[n0+1]);
      end
      checks++;
      if ((q_ferr0[n0] | q_ferr0[n0+1] | q_perr0[n0] | q_perr0[n0+1]) !== 1'b0) begin
        errors++; $display("FAIL b2b_errs got f%b%b p%b%b want 0000",
                           q_ferr0[n0], q_ferr0[n0+1], q_perr0[n0], q_perr0[n0+1]);
      end
    end
  endtask

  task automatic test_no_stray_flags;
    checks++;
    if (stray_err !== 0) begin
      errors++; $display("FAIL stray_err_flags got %0d want 0", stray_err);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    stray_err = 0;
    done_cyc0 = 0;
    start_cyc = 0;
    tick_div  = 1;
    rx0       = 1'b1;
    rx1       = 1'b1;
    test_reset();
    test_basic_8n1();
    test_parity();
    test_break();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    test_no_stray_flags();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
